// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin owner selection for one shared byte serializer. A granted
// requester keeps the serializer until its last byte completes, its request
// drops, or the serializer stops answering and the watchdog aborts the packet.
module uart_tx_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter logic [19:0] TIMEOUT  = 20'd1000000,
    parameter logic [2:0]  BAUD_SET = 3'd0
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     byte_ack,
    output logic [7:0]             data_byte,
    output logic                   send_en,
    output logic [2:0]             baud_set,
    input  logic                   Tx_Done,
    output logic                   busy,
    output logic                   err
);

    localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [19:0] WD_LAST = TIMEOUT - 20'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_gidx;
    logic [IDX_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_byte_ack;
    logic [7:0]           r_data_byte;
    logic                 r_send_en;
    logic                 r_err;
    logic                 r_busy;
    logic [19:0]          r_wd;
    logic                 r_last_q;

    logic                 w_found;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [NUM_REQ-1:0]   w_sel_onehot;
    logic [7:0]           w_cur_byte;
    logic                 w_cur_req;
    logic                 w_cur_last;

    // Index base+offset folded back into 0..NUM_REQ-1 (offset is 1..NUM_REQ).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search: first asserted request strictly after the last owner.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[wrap_add(r_ptr, k)]) begin
                w_found   = 1'b1;
                w_sel_idx = wrap_add(r_ptr, k);
            end
        end
    end

    // One-hot form of the selected requester.
    always_comb begin
        w_sel_onehot            = '0;
        w_sel_onehot[w_sel_idx] = 1'b1;
    end

    // Signals of the current owner only; other requesters are never looked at.
    assign w_cur_byte = req_data[{r_gidx, 3'b000} +: 8];
    assign w_cur_req  = req[r_gidx];
    assign w_cur_last = req_last[r_gidx];

    // Arbitration / pacing FSM with all outputs registered.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_byte_ack  <= '0;
            r_data_byte <= 8'h00;
            r_send_en   <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_wd        <= '0;
            r_last_q    <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            r_send_en  <= 1'b0;
            r_byte_ack <= '0;
            r_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel_onehot;
                        r_gidx  <= w_sel_idx;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    r_state <= S_SEND;
                end

                S_SEND: begin
                    r_data_byte <= w_cur_byte;
                    r_last_q    <= w_cur_last;
                    r_send_en   <= 1'b1;
                    r_byte_ack  <= r_grant;
                    r_wd        <= '0;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (Tx_Done) begin
                        // Completion beats a simultaneous timeout.
                        if (!r_last_q && w_cur_req) begin
                            r_state <= S_SEND;
                        end else begin
                            r_ptr   <= r_gidx;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_ptr   <= r_gidx;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 20'd1;
                    end
                end

                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign byte_ack  = r_byte_ack;
    assign data_byte = r_data_byte;
    assign send_en   = r_send_en;
    assign busy      = r_busy;
    assign err       = r_err;
    assign baud_set  = BAUD_SET;

    // Structural invariants of the scheduler.
    a_grant_onehot0 : assert property (@(posedge Clk) disable iff (!Rst_n)
        $onehot0(r_grant));
    a_send_not_b2b  : assert property (@(posedge Clk) disable iff (!Rst_n)
        r_send_en |=> !r_send_en);
    a_ack_matches   : assert property (@(posedge Clk) disable iff (!Rst_n)
        r_send_en |-> (r_byte_ack == r_grant));
    a_busy_state    : assert property (@(posedge Clk) disable iff (!Rst_n)
        r_busy == (r_state != S_IDLE));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and serializer models plus a scoreboard
// of expected (owner, byte) pairs checked on every send_en.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;

    logic                 Clk;
    logic                 Rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   byte_ack;
    logic [7:0]           data_byte;
    logic                 send_en;
    logic [2:0]           baud_set;
    logic                 Tx_Done;
    logic                 busy;
    logic                 err;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TIMEOUT  (20'd50),
        .BAUD_SET (3'd5)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .grant     (grant),
        .byte_ack  (byte_ack),
        .data_byte (data_byte),
        .send_en   (send_en),
        .baud_set  (baud_set),
        .Tx_Done   (Tx_Done),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [7:0] pkt [NUM_REQ][16] = '{default: '{default: 8'h00}};
    int         pkt_len [NUM_REQ] = '{default: 1};
    int         pos     [NUM_REQ] = '{default: 0};
    int         ack_cnt [NUM_REQ] = '{default: 0};
    int         n_sent    = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    bit         tx_enable = 1'b1;
    int         tx_delay  = 10;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench stopped by global timeout");
    end

    // Requester + serializer model and scoreboard, all evaluated on negedge.
    initial begin
        logic [NUM_REQ-1:0] oh;
        exp_t               e;
        bit                 pending;
        int                 cnt;
        pending  = 1'b0;
        cnt      = 0;
        Tx_Done  = 1'b0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                pending = 1'b0;
                Tx_Done = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) pos[i] = 0;
            end else begin
                Tx_Done = 1'b0;
                if (send_en) begin
                    n_sent++;
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_unexpected_send: grant=%b data_byte=%h, required no send",
                                 grant, data_byte);
                    end else begin
                        e = sb.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        if ({grant, byte_ack, data_byte} !== {oh, oh, e.data}) begin
                            $display("FAIL sb_send: grant=%b ack=%b data=%h, required grant=%b ack=%b data=%h",
                                     grant, byte_ack, data_byte, oh, oh, e.data);
                        end else begin
                            n_pass++;
                        end
                    end
                    n_checks++;
                    if (pending) begin
                        $display("FAIL send_overlap: send_en while previous byte outstanding, required none");
                    end else begin
                        n_pass++;
                    end
                    if (tx_enable) begin
                        pending = 1'b1;
                        cnt     = tx_delay;
                    end
                end else if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        Tx_Done = 1'b1;
                        done_cnt++;
                        pending = 1'b0;
                    end
                end
                if (err) err_cnt++;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (byte_ack[i]) begin
                        ack_cnt[i]++;
                        pos[i] = (pos[i] + 1 >= pkt_len[i]) ? 0 : pos[i] + 1;
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i]) pos[i] = 0;
                req_data[8*i +: 8] = pkt[i][pos[i]];
                req_last[i]        = (pos[i] == pkt_len[i] - 1);
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic load_pkt(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) pkt[r][k] = base + 8'(k);
        pkt_len[r] = n;
    endtask

    task automatic push_exp(input int r, input int first, input int count);
        exp_t e;
        for (int k = first; k < first + count; k++) begin
            e.idx  = r;
            e.data = pkt[r][k];
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        req   = '0;
        #3;
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (byte_ack !== 4'b0000) $display("FAIL reset_ack: got %b required 0000", byte_ack); else n_pass++;
        n_checks++; if (send_en !== 1'b0) $display("FAIL reset_send_en: got %b required 0", send_en); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b required 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (data_byte !== 8'h00) $display("FAIL reset_data: got %h required 00", data_byte); else n_pass++;
        n_checks++; if (baud_set !== 3'd5) $display("FAIL baud_set: got %0d required 5", baud_set); else n_pass++;
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int base_sent = n_sent;
        int base_ack2 = ack_cnt[2];
        load_pkt(0, 1, 8'h10);
        load_pkt(1, 1, 8'h11);
        load_pkt(2, 1, 8'h12);
        load_pkt(3, 1, 8'h13);
        for (int rep = 0; rep < 2; rep++) begin
            push_exp(0, 0, 1);
            push_exp(1, 0, 1);
            push_exp(3, 0, 1);
        end
        req = 4'b1011;
        for (int c = 0; c < 400 && n_sent < base_sent + 6; c++) tick();
        req = 4'b0000;
        n_checks++; if (n_sent !== base_sent + 6) $display("FAIL rr_sends: got %0d required 6", n_sent - base_sent); else n_pass++;
        for (int c = 0; c < 100 && busy; c++) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rr_drain_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (ack_cnt[2] !== base_ack2) $display("FAIL rr_req2_never: got %0d acks required 0", ack_cnt[2] - base_ack2); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        int base_sent = n_sent;
        int base_done = done_cnt;
        int base_ack  = ack_cnt[0];
        pkt[0][0] = 8'h41;
        pkt[0][1] = 8'h42;
        pkt[0][2] = 8'h43;
        pkt_len[0] = 3;
        push_exp(0, 0, 3);
        req = 4'b0001;
        tick();
        n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant_t: got %b required 0001", grant); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_t: got %b required 1", busy); else n_pass++;
        tick();
        n_checks++; if (send_en !== 1'b0) $display("FAIL single_send_t1: got %b required 0", send_en); else n_pass++;
        tick();
        n_checks++; if (send_en !== 1'b1) $display("FAIL single_send_t2: got %b required 1", send_en); else n_pass++;
        for (int c = 0; c < 200 && done_cnt < base_done + 3; c++) tick();
        n_checks++; if (done_cnt !== base_done + 3) $display("FAIL single_done_wait: got %0d required 3", done_cnt - base_done); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL single_release_grant: got %b required 0000", grant); else n_pass++;
        req = 4'b0000;
        n_checks++; if (ack_cnt[0] - base_ack !== 3) $display("FAIL single_acks: got %0d required 3", ack_cnt[0] - base_ack); else n_pass++;
        tick();
        tick();
        n_checks++; if (n_sent - base_sent !== 3) $display("FAIL single_sends: got %0d required 3", n_sent - base_sent); else n_pass++;
    endtask

    task automatic test_contention();
        int base_sent = n_sent;
        int base_ack0 = ack_cnt[0];
        int base_ack2 = ack_cnt[2];
        load_pkt(0, 4, 8'hC0);
        load_pkt(2, 1, 8'hE0);
        push_exp(0, 0, 4);
        push_exp(2, 0, 1);
        req = 4'b0001;
        for (int c = 0; c < 200 && ack_cnt[0] < base_ack0 + 2; c++) tick();
        req = 4'b0101;
        for (int c = 0; c < 300 && n_sent < base_sent + 5; c++) tick();
        req = 4'b0000;
        n_checks++; if (n_sent - base_sent !== 5) $display("FAIL cont_sends: got %0d required 5", n_sent - base_sent); else n_pass++;
        n_checks++; if (ack_cnt[0] - base_ack0 !== 4) $display("FAIL cont_acks0: got %0d required 4", ack_cnt[0] - base_ack0); else n_pass++;
        n_checks++; if (ack_cnt[2] - base_ack2 !== 1) $display("FAIL cont_acks2: got %0d required 1", ack_cnt[2] - base_ack2); else n_pass++;
        for (int c = 0; c < 100 && busy; c++) tick();
        tick();
    endtask

    task automatic test_early_drop();
        int base_sent = n_sent;
        int base_done = done_cnt;
        int base_ack  = ack_cnt[1];
        int base_err  = err_cnt;
        load_pkt(1, 5, 8'h51);
        push_exp(1, 0, 2);
        req = 4'b0010;
        for (int c = 0; c < 200 && ack_cnt[1] < base_ack + 2; c++) tick();
        req = 4'b0000;
        for (int c = 0; c < 200 && done_cnt < base_done + 2; c++) tick();
        n_checks++; if (done_cnt !== base_done + 2) $display("FAIL drop_done_wait: got %0d required 2", done_cnt - base_done); else n_pass++;
        tick();
        n_checks++; if (grant !== 4'b0000) $display("FAIL drop_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b required 0", busy); else n_pass++;
        for (int c = 0; c < 15; c++) tick();
        n_checks++; if (n_sent - base_sent !== 2) $display("FAIL drop_sends: got %0d required 2", n_sent - base_sent); else n_pass++;
        n_checks++; if (err_cnt !== base_err) $display("FAIL drop_err: got %0d pulses required 0", err_cnt - base_err); else n_pass++;
    endtask

    task automatic test_watchdog();
        int base_sent = n_sent;
        int base_err  = err_cnt;
        int base_done = done_cnt;
        int elapsed   = 0;
        tx_enable = 1'b0;
        load_pkt(3, 2, 8'h70);
        push_exp(3, 0, 1);
        req = 4'b1000;
        for (int c = 0; c < 50 && n_sent < base_sent + 1; c++) tick();
        for (int c = 0; c < 200 && !err; c++) begin
            tick();
            elapsed++;
        end
        req = 4'b0000;
        n_checks++; if (elapsed !== 50) $display("FAIL wd_latency: got %0d cycles required 50", elapsed); else n_pass++;
        n_checks++; if (grant !== 4'b0000) $display("FAIL wd_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL wd_busy: got %b required 0", busy); else n_pass++;
        tick();
        n_checks++; if (err !== 1'b0) $display("FAIL wd_err_pulse: got %b required 0", err); else n_pass++;
        n_checks++; if (err_cnt - base_err !== 1) $display("FAIL wd_err_count: got %0d required 1", err_cnt - base_err); else n_pass++;
        tx_enable = 1'b1;
        load_pkt(1, 1, 8'h99);
        push_exp(1, 0, 1);
        req = 4'b0010;
        for (int c = 0; c < 200 && done_cnt < base_done + 1; c++) tick();
        tick();
        req = 4'b0000;
        n_checks++; if (grant !== 4'b0000) $display("FAIL wd_next_release: got %b required 0000", grant); else n_pass++;
        n_checks++; if (n_sent - base_sent !== 2) $display("FAIL wd_next_sends: got %0d required 2", n_sent - base_sent); else n_pass++;
        n_checks++; if (err_cnt - base_err !== 1) $display("FAIL wd_next_err: got %0d required 1", err_cnt - base_err); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int base_sent;
        int base_done;
        load_pkt(0, 3, 8'hA0);
        push_exp(0, 0, 1);
        base_sent = n_sent;
        req = 4'b0001;
        for (int c = 0; c < 50 && n_sent < base_sent + 1; c++) tick();
        tick();
        tick();
        Rst_n = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000) $display("FAIL rmid_grant: got %b required 0000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if ({send_en, err, byte_ack} !== 6'b0) $display("FAIL rmid_pulses: got %b required 000000", {send_en, err, byte_ack}); else n_pass++;
        n_checks++; if (data_byte !== 8'h00) $display("FAIL rmid_data: got %h required 00", data_byte); else n_pass++;
        tick();
        tick();
        push_exp(0, 0, 3);
        base_done = done_cnt;
        base_sent = n_sent;
        Rst_n = 1'b1;
        tick();
        n_checks++; if (grant !== 4'b0001) $display("FAIL rmid_regrant: got %b required 0001", grant); else n_pass++;
        tick();
        n_checks++; if (send_en !== 1'b0) $display("FAIL rmid_send_t1: got %b required 0", send_en); else n_pass++;
        tick();
        n_checks++; if (send_en !== 1'b1) $display("FAIL rmid_send_t2: got %b required 1", send_en); else n_pass++;
        for (int c = 0; c < 200 && done_cnt < base_done + 3; c++) tick();
        tick();
        req = 4'b0000;
        n_checks++; if (n_sent - base_sent !== 3) $display("FAIL rmid_sends: got %0d required 3", n_sent - base_sent); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_contention();
        test_early_drop();
        test_watchdog();
        test_reset_mid();
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
